// File: rtl/exe_mem_req.sv
// Execute-stage data-SRAM request issuer: drives the req/addr_ok handshake,
// formats store lanes, flags misaligned accesses and counts in-flight data_ok.
module exe_mem_req #(
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        es_valid,
   input  logic        ms_allowin,
   input  logic        flush,
   input  logic        es_ex,
   input  logic        younger_ex,
   input  logic        mem_re,
   input  logic        mem_we,
   input  logic [1:0]  mem_size,
   input  logic [31:0] vaddr,
   input  logic [31:0] st_data,
   output logic        data_sram_req,
   output logic        data_sram_wr,
   output logic [1:0]  data_sram_size,
   output logic [3:0]  data_sram_wstrb,
   output logic [31:0] data_sram_addr,
   output logic [31:0] data_sram_wdata,
   input  logic        data_sram_addr_ok,
   input  logic        data_sram_data_ok,
   output logic        ale_ex,
   output logic        mem_ready_go,
   output logic [1:0]  outstanding
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      DONE   = 2'd2,
      CANCEL = 2'd3
   } state_t;

   localparam logic [1:0] MAX_C = 2'(MAX_OUTSTANDING);

   state_t      state_r, state_s;
   logic        mem_op_s, misalign_s, can_issue_s, accept_s, ready_s;
   logic [3:0]  wstrb_s;
   logic [31:0] wdata_s;
   logic        req_r, wr_r;
   logic [1:0]  size_r, outstanding_r;
   logic [3:0]  wstrb_r;
   logic [31:0] addr_r, wdata_r;

   assign mem_op_s    = mem_re | mem_we;
   assign ale_ex      = es_valid & mem_op_s & misalign_s;
   assign can_issue_s = es_valid & mem_op_s & ~ale_ex & ~es_ex & ~younger_ex & ~flush
                        & (outstanding_r < MAX_C);
   assign accept_s    = req_r & data_sram_addr_ok;

   // Alignment check; size 3 is handled as a word.
   always_comb begin
      misalign_s = 1'b0;
      case (mem_size)
         2'd0:    misalign_s = 1'b0;
         2'd1:    misalign_s = vaddr[0];
         default: misalign_s = (vaddr[1:0] != 2'b00);
      endcase
   end

   // Store byte-enable and lane replication.
   always_comb begin
      wstrb_s = 4'b0000;
      wdata_s = st_data;
      case (mem_size)
         2'd0: begin
            wstrb_s = 4'b0001 << vaddr[1:0];
            wdata_s = {4{st_data[7:0]}};
         end
         2'd1: begin
            wstrb_s = vaddr[1] ? 4'b1100 : 4'b0011;
            wdata_s = {2{st_data[15:0]}};
         end
         default: begin
            wstrb_s = 4'b1111;
            wdata_s = st_data;
         end
      endcase
      if (!mem_we) begin
         wstrb_s = 4'b0000;
      end else begin
         wstrb_s = wstrb_s;
      end
   end

   // Handshake next-state and ready_go contribution.
   always_comb begin
      state_s = state_r;
      ready_s = ~mem_op_s | ale_ex | es_ex | younger_ex;
      case (state_r)
         IDLE: begin
            if (can_issue_s) state_s = REQ;
            else             state_s = IDLE;
         end
         REQ: begin
            if (data_sram_addr_ok) begin
               if (flush) begin
                  state_s = IDLE;
               end else begin
                  state_s = DONE;
                  ready_s = 1'b1;
               end
            end else if (flush) begin
               state_s = CANCEL;
            end else begin
               state_s = REQ;
            end
         end
         DONE: begin
            ready_s = 1'b1;
            if (flush || ms_allowin) state_s = IDLE;
            else                     state_s = DONE;
         end
         CANCEL: begin
            if (data_sram_addr_ok) state_s = IDLE;
            else                   state_s = CANCEL;
         end
         default: state_s = IDLE;
      endcase
   end

   // State and request-valid registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r <= IDLE;
         req_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         req_r   <= (state_s == REQ) || (state_s == CANCEL);
      end
   end

   // Payload is captured only on issue so it stays frozen until addr_ok.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_r    <= 1'b0;
         size_r  <= 2'd0;
         wstrb_r <= 4'b0000;
         addr_r  <= 32'h0000_0000;
         wdata_r <= 32'h0000_0000;
      end else if ((state_r == IDLE) && can_issue_s) begin
         wr_r    <= mem_we;
         size_r  <= mem_size;
         wstrb_r <= wstrb_s;
         addr_r  <= vaddr;
         wdata_r <= wdata_s;
      end else begin
         wr_r    <= wr_r;
         size_r  <= size_r;
         wstrb_r <= wstrb_r;
         addr_r  <= addr_r;
         wdata_r <= wdata_r;
      end
   end

   // In-flight counter; cancelled handshakes still return data_ok.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         outstanding_r <= 2'd0;
      end else begin
         case ({accept_s, data_sram_data_ok})
            2'b10: begin
               if (outstanding_r < MAX_C) outstanding_r <= outstanding_r + 2'd1;
               else                       outstanding_r <= outstanding_r;
            end
            2'b01: begin
               if (outstanding_r != 2'd0) outstanding_r <= outstanding_r - 2'd1;
               else                       outstanding_r <= outstanding_r;
            end
            default: outstanding_r <= outstanding_r;
         endcase
      end
   end

   assign data_sram_req   = req_r;
   assign data_sram_wr    = wr_r;
   assign data_sram_size  = size_r;
   assign data_sram_wstrb = wstrb_r;
   assign data_sram_addr  = addr_r;
   assign data_sram_wdata = wdata_r;
   assign mem_ready_go    = ready_s;
   assign outstanding     = outstanding_r;

endmodule

// File: tb/tb_exe_mem_req.sv
// Directed bench for exe_mem_req: hand-computed expectations on the SRAM
// request port, ALE, ready_go and the outstanding counter.
module tb_exe_mem_req;

   logic        clk = 1'b0;
   logic        resetn, es_valid, ms_allowin, flush, es_ex, younger_ex;
   logic        mem_re, mem_we;
   logic [1:0]  mem_size;
   logic [31:0] vaddr, st_data;
   logic        data_sram_req, data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr, data_sram_wdata;
   logic        data_sram_addr_ok, data_sram_data_ok;
   logic        ale_ex, mem_ready_go;
   logic [1:0]  outstanding;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   exe_mem_req #(.MAX_OUTSTANDING(2)) dut (
      .clk               (clk),
      .resetn            (resetn),
      .es_valid          (es_valid),
      .ms_allowin        (ms_allowin),
      .flush             (flush),
      .es_ex             (es_ex),
      .younger_ex        (younger_ex),
      .mem_re            (mem_re),
      .mem_we            (mem_we),
      .mem_size          (mem_size),
      .vaddr             (vaddr),
      .st_data           (st_data),
      .data_sram_req     (data_sram_req),
      .data_sram_wr      (data_sram_wr),
      .data_sram_size    (data_sram_size),
      .data_sram_wstrb   (data_sram_wstrb),
      .data_sram_addr    (data_sram_addr),
      .data_sram_wdata   (data_sram_wdata),
      .data_sram_addr_ok (data_sram_addr_ok),
      .data_sram_data_ok (data_sram_data_ok),
      .ale_ex            (ale_ex),
      .mem_ready_go      (mem_ready_go),
      .outstanding       (outstanding)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full load that is accepted on the first REQ cycle and then advances.
   task automatic load_txn(input logic [31:0] a);
      es_valid = 1'b1; mem_re = 1'b1; mem_size = 2'd2; vaddr = a;
      step();
      data_sram_addr_ok = 1'b1;
      step();
      data_sram_addr_ok = 1'b0; ms_allowin = 1'b1;
      step();
      ms_allowin = 1'b0;
   endtask

   initial begin
      resetn = 1'b0; es_valid = 1'b0; ms_allowin = 1'b0; flush = 1'b0;
      es_ex = 1'b0; younger_ex = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
      mem_size = 2'd0; vaddr = 32'h0; st_data = 32'h0;
      data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
      step(); step();
      #1;
      check_val("rst_req",   {31'd0, data_sram_req}, 32'd0);
      check_val("rst_wr",    {31'd0, data_sram_wr}, 32'd0);
      check_val("rst_size",  {30'd0, data_sram_size}, 32'd0);
      check_val("rst_wstrb", {28'd0, data_sram_wstrb}, 32'd0);
      check_val("rst_addr",  data_sram_addr, 32'd0);
      check_val("rst_wdata", data_sram_wdata, 32'd0);
      check_val("rst_outst", {30'd0, outstanding}, 32'd0);
      resetn = 1'b1;

      // byte store at 0x1003, addr_ok on second REQ cycle
      es_valid = 1'b1; mem_we = 1'b1; mem_size = 2'd0; vaddr = 32'h1003; st_data = 32'hA5;
      #1;
      check_val("t1_ale", {31'd0, ale_ex}, 32'd0);
      check_val("t1_rg_idle", {31'd0, mem_ready_go}, 32'd0);
      step();
      vaddr = 32'h1000; st_data = 32'h0;
      #1;
      check_val("t1_req1", {31'd0, data_sram_req}, 32'd1);
      check_val("t1_wstrb", {28'd0, data_sram_wstrb}, 32'h8);
      check_val("t1_wdata", data_sram_wdata, 32'hA5A5_A5A5);
      check_val("t1_addr", data_sram_addr, 32'h1003);
      check_val("t1_wr", {31'd0, data_sram_wr}, 32'd1);
      check_val("t1_rg_req", {31'd0, mem_ready_go}, 32'd0);
      step();
      data_sram_addr_ok = 1'b1;
      #1;
      check_val("t1_req2", {31'd0, data_sram_req}, 32'd1);
      check_val("t1_addr2", data_sram_addr, 32'h1003);
      check_val("t1_wdata2", data_sram_wdata, 32'hA5A5_A5A5);
      check_val("t1_rg_ack", {31'd0, mem_ready_go}, 32'd1);
      step();
      data_sram_addr_ok = 1'b0;
      #1;
      check_val("t1_req_done", {31'd0, data_sram_req}, 32'd0);
      check_val("t1_rg_done", {31'd0, mem_ready_go}, 32'd1);
      check_val("t1_outst", {30'd0, outstanding}, 32'd1);
      ms_allowin = 1'b1; data_sram_data_ok = 1'b1;
      step();
      ms_allowin = 1'b0; data_sram_data_ok = 1'b0; es_valid = 1'b0; mem_we = 1'b0;
      #1;
      check_val("t1_outst0", {30'd0, outstanding}, 32'd0);

      // misaligned half load
      es_valid = 1'b1; mem_re = 1'b1; mem_size = 2'd1; vaddr = 32'h2001;
      #1;
      check_val("t2_ale", {31'd0, ale_ex}, 32'd1);
      check_val("t2_rg", {31'd0, mem_ready_go}, 32'd1);
      step();
      check_val("t2_req_a", {31'd0, data_sram_req}, 32'd0);
      step();
      check_val("t2_req_b", {31'd0, data_sram_req}, 32'd0);
      check_val("t2_outst", {30'd0, outstanding}, 32'd0);
      es_valid = 1'b0; mem_re = 1'b0;

      // word load flushed in REQ, addr_ok three cycles later
      es_valid = 1'b1; mem_re = 1'b1; mem_size = 2'd2; vaddr = 32'h3000;
      step();
      flush = 1'b1;
      #1;
      check_val("t3_req", {31'd0, data_sram_req}, 32'd1);
      check_val("t3_wstrb", {28'd0, data_sram_wstrb}, 32'd0);
      check_val("t3_rg", {31'd0, mem_ready_go}, 32'd0);
      step();
      flush = 1'b0; es_valid = 1'b0; mem_re = 1'b0;
      #1;
      check_val("t3_cancel_req", {31'd0, data_sram_req}, 32'd1);
      check_val("t3_cancel_addr", data_sram_addr, 32'h3000);
      step();
      check_val("t3_cancel_req2", {31'd0, data_sram_req}, 32'd1);
      step();
      data_sram_addr_ok = 1'b1;
      #1;
      check_val("t3_cancel_req3", {31'd0, data_sram_req}, 32'd1);
      step();
      data_sram_addr_ok = 1'b0;
      #1;
      check_val("t3_idle_req", {31'd0, data_sram_req}, 32'd0);
      check_val("t3_outst1", {30'd0, outstanding}, 32'd1);
      data_sram_data_ok = 1'b1;
      step();
      data_sram_data_ok = 1'b0;
      #1;
      check_val("t3_outst0", {30'd0, outstanding}, 32'd0);

      // two loads fill the counter, the third waits for data_ok
      load_txn(32'h4000);
      load_txn(32'h4004);
      check_val("t4_outst2", {30'd0, outstanding}, 32'd2);
      vaddr = 32'h4008;
      #1;
      check_val("t4_rg_hold", {31'd0, mem_ready_go}, 32'd0);
      step();
      check_val("t4_req_hold_a", {31'd0, data_sram_req}, 32'd0);
      step();
      check_val("t4_req_hold_b", {31'd0, data_sram_req}, 32'd0);
      check_val("t4_rg_hold_b", {31'd0, mem_ready_go}, 32'd0);
      data_sram_data_ok = 1'b1;
      #1;
      check_val("t4_req_dok", {31'd0, data_sram_req}, 32'd0);
      step();
      data_sram_data_ok = 1'b0;
      #1;
      check_val("t4_outst_dec", {30'd0, outstanding}, 32'd1);
      check_val("t4_req_nobypass", {31'd0, data_sram_req}, 32'd0);
      step();
      check_val("t4_req_issue", {31'd0, data_sram_req}, 32'd1);
      check_val("t4_addr", data_sram_addr, 32'h4008);
      data_sram_addr_ok = 1'b1;
      step();
      data_sram_addr_ok = 1'b0; es_valid = 1'b0; mem_re = 1'b0; ms_allowin = 1'b1;
      step();
      ms_allowin = 1'b0;
      #1;
      check_val("t4_outst_full", {30'd0, outstanding}, 32'd2);
      data_sram_data_ok = 1'b1;
      step();
      data_sram_data_ok = 1'b0;
      #1;
      check_val("t4_outst_drain", {30'd0, outstanding}, 32'd1);

      // younger exception blocks a half store; then simultaneous addr_ok/data_ok
      es_valid = 1'b1; mem_we = 1'b1; mem_size = 2'd1; vaddr = 32'h5002;
      st_data = 32'h1234_BEEF; younger_ex = 1'b1;
      #1;
      check_val("t5_rg_yex", {31'd0, mem_ready_go}, 32'd1);
      step();
      check_val("t5_req_yex", {31'd0, data_sram_req}, 32'd0);
      younger_ex = 1'b0;
      step();
      check_val("t5_wstrb", {28'd0, data_sram_wstrb}, 32'hC);
      check_val("t5_wdata", data_sram_wdata, 32'hBEEF_BEEF);
      check_val("t5_size", {30'd0, data_sram_size}, 32'd1);
      data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1;
      step();
      data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
      #1;
      check_val("t5_outst_net0", {30'd0, outstanding}, 32'd1);
      check_val("t5_rg_done", {31'd0, mem_ready_go}, 32'd1);
      flush = 1'b1; es_valid = 1'b0; mem_we = 1'b0;
      step();
      flush = 1'b0;
      #1;
      check_val("t5_req_flush", {31'd0, data_sram_req}, 32'd0);
      data_sram_data_ok = 1'b1;
      step();
      data_sram_data_ok = 1'b0;
      #1;
      check_val("t5_outst0", {30'd0, outstanding}, 32'd0);

      // reset asserted while in REQ
      es_valid = 1'b1; mem_re = 1'b1; mem_size = 2'd2; vaddr = 32'h7000;
      step();
      check_val("t6_req", {31'd0, data_sram_req}, 32'd1);
      resetn = 1'b0; es_valid = 1'b0; mem_re = 1'b0;
      step();
      check_val("t6_req_rst", {31'd0, data_sram_req}, 32'd0);
      check_val("t6_outst_rst", {30'd0, outstanding}, 32'd0);
      check_val("t6_addr_rst", data_sram_addr, 32'd0);
      resetn = 1'b1; es_valid = 1'b1; mem_re = 1'b1; vaddr = 32'h7004;
      #1;
      check_val("t6_rg_idle", {31'd0, mem_ready_go}, 32'd0);
      step();
      check_val("t6_req_again", {31'd0, data_sram_req}, 32'd1);
      check_val("t6_addr_again", data_sram_addr, 32'h7004);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
